fifo_enq_arbiter: RTL

//  Shares the enqueue side of one fifo_xb among NREQ producers using valid/ready handshakes.

---
 rtl/fifo_enq_arbiter.sv | 131 +++++++++++++
 1 files changed

// File: rtl/fifo_enq_arbiter.sv
// fifo_enq_arbiter: round-robin, burst-bounded sharing of one fifo_xb enqueue port
// among NREQ valid/ready producers. Zero latency: the word is written into the fifo
// on the same edge that completes the producer handshake.

// Per-requester slice: turns the shared grant into this lane's ready bit and
// contributes its data to the OR-reduced fifo write bus.
module fifo_enq_lane #(
  parameter int WIDTH = 8
) (
  input  logic             sel,
  input  logic [WIDTH-1:0] data,
  output logic             ready,
  output logic [WIDTH-1:0] dout
);
  assign ready = sel;
  assign dout  = sel ? data : '0;
endmodule

module fifo_enq_arbiter #(
  parameter int WIDTH    = 8,
  parameter int NREQ     = 4,
  parameter int MAXBURST = 2
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [NREQ-1:0]         req_valid,
  input  logic [NREQ*WIDTH-1:0]   req_data,
  output logic [NREQ-1:0]         req_ready,
  input  logic                    full,
  output logic                    enqueue,
  output logic [WIDTH-1:0]        din,
  output logic [$clog2(NREQ)-1:0] grant_id,
  output logic                    locked
);
  localparam int PW = $clog2(NREQ);
  localparam int BW = $clog2(MAXBURST+1);

  logic [PW-1:0] owner, ptr, start, scan, cand;
  logic [BW-1:0] bcnt;
  logic          lock_q;
  logic          hold, found, xfer, go;
  logic [NREQ-1:0][WIDTH-1:0] lane_dout;

  // Modulo-NREQ increment; explicit compare so non-power-of-2 NREQ wraps correctly.
  function automatic logic [PW-1:0] wrap_inc(input logic [PW-1:0] x);
    return (x == PW'(NREQ-1)) ? '0 : x + 1'b1;
  endfunction

  // Pick the candidate: the locked owner while it stays valid, otherwise the first
  // valid requester from ptr (or owner+1 when a lock is being released this cycle).
  always_comb begin
    int s;
    s     = 0;
    hold  = lock_q && req_valid[owner];
    start = lock_q ? wrap_inc(owner) : ptr;
    found = 1'b0;
    scan  = '0;
    for (int k = 0; k < NREQ; k++) begin
      s = int'(start) + k;
      if (s >= NREQ) s = s - NREQ;
      if (!found && req_valid[PW'(s)]) begin
        found = 1'b1;
        scan  = PW'(s);
      end
    end
    cand = hold ? owner : scan;
    xfer = !full && (hold || found);
  end

  assign go = !rst && xfer;

  genvar g;
  generate
    for (g = 0; g < NREQ; g++) begin : g_lane
      fifo_enq_lane #(.WIDTH(WIDTH)) u_lane (
        .sel   (go && (cand == PW'(g))),
        .data  (req_data[g*WIDTH +: WIDTH]),
        .ready (req_ready[g]),
        .dout  (lane_dout[g])
      );
    end
  endgenerate

  // At most one lane is selected, so OR-reduction is a mux.
  always_comb begin
    din = '0;
    for (int i = 0; i < NREQ; i++) din = din | lane_dout[i];
  end

  assign enqueue  = go;
  assign grant_id = rst ? '0 : owner;
  assign locked   = rst ? 1'b0 : lock_q;

  // Arbitration state: burst count while locked, rotation pointer when released.
  always_ff @(posedge clk) begin
    if (rst) begin
      owner  <= '0;
      ptr    <= '0;
      lock_q <= 1'b0;
      bcnt   <= '0;
    end else if (hold) begin
      // Owner still valid: a full fifo simply stalls the burst in place.
      if (!full) begin
        if ((bcnt + BW'(1)) == BW'(MAXBURST)) begin
          lock_q <= 1'b0;
          bcnt   <= '0;
          ptr    <= wrap_inc(owner);
        end else begin
          bcnt <= bcnt + BW'(1);
        end
      end
    end else begin
      // Owner dropped valid: release now; a new winner below overrides these.
      if (lock_q) begin
        ptr    <= wrap_inc(owner);
        lock_q <= 1'b0;
        bcnt   <= '0;
      end
      if (xfer) begin
        owner <= cand;
        if (MAXBURST == 1) begin
          ptr    <= wrap_inc(cand);
          lock_q <= 1'b0;
        end else begin
          lock_q <= 1'b1;
          bcnt   <= BW'(1);
        end
      end
    end
  end
endmodule
